// File: rtl/router_pkt_tx.sv
// router_pkt_tx
//
// Packet transmitter feeding a router. A host posts a request (destination
// address + payload length), then streams the payload bytes into a local
// 64x8 buffer. Once the whole payload is buffered the packet goes out as a
// header byte, the payload bytes and a trailing XOR parity byte, followed by a
// fixed number of idle gap cycles during which the router's parity-error flag
// is sampled.
//
// Parameters
//   GAP_CYCLES  idle cycles after each parity byte (1..15)
//
// Ports
//   clock       single clock, rising edge
//   reset       synchronous, active-high
//   req_valid   host request valid
//   req_addr    destination port (0..2; 3 is illegal)
//   req_len     payload length in bytes (1..63; 0 is illegal)
//   req_ready   request accepted when req_valid & req_ready at a rising edge
//   pay_valid   payload byte valid
//   pay_data    payload byte
//   pay_ready   payload byte accepted when pay_valid & pay_ready
//   busy        router stall; data_out is not consumed while high
//   err         router parity-error flag
//   pkt_valid   high during header and payload bytes
//   data_out    packet byte to the router
//   tx_done     one-cycle pulse after the parity byte is consumed
//   drop        one-cycle pulse after an illegal request is discarded
//   err_count   packets that drew err during their gap, saturating at 255

module router_pkt_tx #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_addr,
    input  logic [5:0] req_len,
    output logic       req_ready,
    input  logic       pay_valid,
    input  logic [7:0] pay_data,
    output logic       pay_ready,
    input  logic       busy,
    input  logic       err,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_done,
    output logic       drop,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHeader,
        StPayload,
        StParity,
        StGap
    } state_e;

    localparam logic [3:0] GapLast = 4'(GAP_CYCLES - 1);

    state_e     state_q;
    logic [1:0] addr_q;
    logic [5:0] len_q;
    logic [5:0] wr_idx_q;
    logic [5:0] rd_idx_q;
    logic [7:0] parity_q;
    logic [3:0] gap_cnt_q;
    logic       err_seen_q;

    logic       req_ready_q;
    logic       pay_ready_q;
    logic       pkt_valid_q;
    logic [7:0] data_out_q;
    logic       tx_done_q;
    logic       drop_q;
    logic [7:0] err_count_q;

    // Payload buffer; contents are don't-care after reset so it has none.
    logic [7:0] pkt_mem [64];

    logic       pay_fire;
    logic       req_legal;
    logic       last_wr;
    logic       last_rd;
    logic [7:0] header;

    always_comb begin
        pay_fire  = pay_valid && pay_ready_q;
        req_legal = (req_addr != 2'd3) && (req_len != 6'd0);
        last_wr   = (wr_idx_q == (len_q - 6'd1));
        last_rd   = (rd_idx_q == (len_q - 6'd1));
        header    = {len_q, addr_q};
    end

    always_ff @(posedge clock) begin
        if (pay_fire) begin
            pkt_mem[wr_idx_q] <= pay_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= 2'd0;
            len_q       <= 6'd0;
            wr_idx_q    <= 6'd0;
            rd_idx_q    <= 6'd0;
            parity_q    <= 8'd0;
            gap_cnt_q   <= 4'd0;
            err_seen_q  <= 1'b0;
            req_ready_q <= 1'b1;
            pay_ready_q <= 1'b0;
            pkt_valid_q <= 1'b0;
            data_out_q  <= 8'd0;
            tx_done_q   <= 1'b0;
            drop_q      <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            tx_done_q <= 1'b0;
            drop_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid && req_ready_q) begin
                        if (req_legal) begin
                            addr_q      <= req_addr;
                            len_q       <= req_len;
                            wr_idx_q    <= 6'd0;
                            req_ready_q <= 1'b0;
                            pay_ready_q <= 1'b1;
                            state_q     <= StLoad;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (pay_fire) begin
                        wr_idx_q <= wr_idx_q + 6'd1;
                        if (last_wr) begin
                            // Whole payload buffered: present the header and
                            // seed the running parity with it.
                            pay_ready_q <= 1'b0;
                            pkt_valid_q <= 1'b1;
                            data_out_q  <= header;
                            parity_q    <= header;
                            rd_idx_q    <= 6'd0;
                            state_q     <= StHeader;
                        end
                    end
                end
                StHeader: begin
                    if (!busy) begin
                        data_out_q <= pkt_mem[6'd0];
                        rd_idx_q   <= 6'd0;
                        state_q    <= StPayload;
                    end
                end
                StPayload: begin
                    if (!busy) begin
                        parity_q <= parity_q ^ data_out_q;
                        if (last_rd) begin
                            pkt_valid_q <= 1'b0;
                            data_out_q  <= parity_q ^ data_out_q;
                            state_q     <= StParity;
                        end else begin
                            rd_idx_q   <= rd_idx_q + 6'd1;
                            data_out_q <= pkt_mem[rd_idx_q + 6'd1];
                        end
                    end
                end
                StParity: begin
                    if (!busy) begin
                        tx_done_q  <= 1'b1;
                        data_out_q <= 8'd0;
                        gap_cnt_q  <= 4'd0;
                        err_seen_q <= 1'b0;
                        state_q    <= StGap;
                    end
                end
                StGap: begin
                    // err may stay high for several gap cycles; count it once.
                    if (err && !err_seen_q) begin
                        err_seen_q <= 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                    end
                    if (gap_cnt_q == GapLast) begin
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    pay_ready_q <= 1'b0;
                    pkt_valid_q <= 1'b0;
                    data_out_q  <= 8'd0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign pay_ready = pay_ready_q;
    assign pkt_valid = pkt_valid_q;
    assign data_out  = data_out_q;
    assign tx_done   = tx_done_q;
    assign drop      = drop_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Testbench for router_pkt_tx: scoreboard of expected packet bytes and
// parities filled by the driver, drained by a monitor on the falling edge.

module tb_router_pkt_tx;

    localparam int unsigned Gap = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       req_ready;
    logic       pay_valid;
    logic [7:0] pay_data;
    logic       pay_ready;
    logic       busy;
    logic       err;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_done;
    logic       drop;
    logic [7:0] err_count;

    router_pkt_tx #(
        .GAP_CYCLES(Gap)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_len  (req_len),
        .req_ready(req_ready),
        .pay_valid(pay_valid),
        .pay_data (pay_data),
        .pay_ready(pay_ready),
        .busy     (busy),
        .err      (err),
        .pkt_valid(pkt_valid),
        .data_out (data_out),
        .tx_done  (tx_done),
        .drop     (drop),
        .err_count(err_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_par_q[$];
    logic [7:0] pl [64];

    int tx_done_cnt = 0;
    int drop_cnt    = 0;
    int pv_cycles   = 0;
    int pr_cycles   = 0;
    int bb_cycles   = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Falling-edge monitor: pops a byte each time one is consumed.
    task automatic run_monitor();
        bit         pv_last  = 1'b0;
        bit         in_par   = 1'b0;
        bit         exp_done = 1'b0;
        logic [7:0] par_val  = 8'd0;
        forever begin
            @(negedge clock);
            if (reset) begin
                pv_last  = 1'b0;
                in_par   = 1'b0;
                exp_done = 1'b0;
                exp_q.delete();
                exp_par_q.delete();
            end else begin
                if (tx_done) tx_done_cnt++;
                if (drop) drop_cnt++;
                if (pkt_valid) pv_cycles++;
                if (pay_ready) pr_cycles++;
                if (pkt_valid && data_out == 8'hBB) bb_cycles++;
                if (exp_done) begin
                    check_val("tx_done_pulse", 32'(tx_done), 32'd1);
                    exp_done = 1'b0;
                end else if (tx_done) begin
                    check_val("tx_done_spurious", 32'(tx_done), 32'd0);
                end
                if (pkt_valid) begin
                    if (!busy) begin
                        if (exp_q.size() == 0) check_val("byte_extra", 32'(exp_q.size()), 32'd1);
                        else check_val("byte", 32'(data_out), 32'(exp_q.pop_front()));
                    end
                end else if (pv_last) begin
                    if (exp_par_q.size() == 0) begin
                        check_val("parity_extra", 32'(exp_par_q.size()), 32'd1);
                    end else begin
                        par_val = exp_par_q.pop_front();
                        in_par  = 1'b1;
                    end
                end
                if (in_par) begin
                    check_val("parity", 32'(data_out), 32'(par_val));
                    if (!busy) begin
                        in_par   = 1'b0;
                        exp_done = 1'b1;
                    end
                end
                pv_last = pkt_valid && !busy;
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue a request; for a legal one, push expectations and load payload pl[].
    task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input bit gaps);
        int         budget;
        bit         legal;
        logic [7:0] p;
        budget = 0;
        while (!req_ready && budget < 200) begin
            step();
            budget++;
        end
        check_val("req_ready_wait", 32'(req_ready), 32'd1);
        legal = (a != 2'd3) && (l != 6'd0);
        if (legal) begin
            p = {l, a};
            exp_q.push_back(p);
            for (int i = 0; i < int'(l); i++) begin
                exp_q.push_back(pl[i]);
                p = p ^ pl[i];
            end
            exp_par_q.push_back(p);
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        step();
        req_valid = 1'b0;
        if (legal) begin
            for (int i = 0; i < int'(l); i++) begin
                if (gaps) repeat ($urandom_range(0, 2)) step();
                pay_valid = 1'b1;
                pay_data  = pl[i];
                budget = 0;
                while (!pay_ready && budget < 50) begin
                    step();
                    budget++;
                end
                check_val("pay_ready_wait", 32'(pay_ready), 32'd1);
                step();
                pay_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_pkt_end();
        int budget;
        int k;
        budget = 0;
        while (!tx_done && budget < 500) begin
            step();
            budget++;
        end
        check_val("tx_done_seen", 32'(tx_done), 32'd1);
        k = 0;
        while (!req_ready && k < 20) begin
            check_val("gap_data", 32'({pkt_valid, data_out}), 32'd0);
            step();
            k++;
        end
        check_val("gap_len", 32'(k), 32'(Gap));
        check_val("sb_empty", 32'(exp_q.size() + exp_par_q.size()), 32'd0);
    endtask

    initial begin
        int td0;
        int dr0;
        int pv0;
        int pr0;
        int budget;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 2'd0;
        req_len   = 6'd0;
        pay_valid = 1'b0;
        pay_data  = 8'd0;
        busy      = 1'b0;
        err       = 1'b0;
        fork
            run_monitor();
        join_none

        repeat (3) step();
        check_val("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check_val("rst_data_out", 32'(data_out), 32'd0);
        check_val("rst_tx_done", 32'(tx_done), 32'd0);
        check_val("rst_drop", 32'(drop), 32'd0);
        check_val("rst_err_count", 32'(err_count), 32'd0);
        check_val("rst_pay_ready", 32'(pay_ready), 32'd0);
        reset = 1'b0;
        step();
        check_val("req_ready_after_rst", 32'(req_ready), 32'd1);

        // Basic packet: 0D AA BB CC, parity D0.
        pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
        bb_cycles = 0;
        td0 = tx_done_cnt;
        send_pkt(2'd1, 6'd3, 1'b0);
        wait_pkt_end();
        check_val("basic_bb_cycles", 32'(bb_cycles), 32'd1);
        check_val("basic_tx_done_cnt", 32'(tx_done_cnt - td0), 32'd1);

        // Same packet with a 3-cycle stall on BB.
        bb_cycles = 0;
        td0 = tx_done_cnt;
        send_pkt(2'd1, 6'd3, 1'b1);
        budget = 0;
        while (!(pkt_valid && data_out == 8'hBB) && budget < 50) begin
            step();
            budget++;
        end
        check_val("busy_bb_seen", 32'(data_out), 32'h0BB);
        busy = 1'b1;
        repeat (3) step();
        busy = 1'b0;
        wait_pkt_end();
        check_val("busy_bb_cycles", 32'(bb_cycles), 32'd4);
        check_val("busy_tx_done_cnt", 32'(tx_done_cnt - td0), 32'd1);

        // Illegal requests.
        dr0 = drop_cnt; pv0 = pv_cycles; pr0 = pr_cycles;
        send_pkt(2'd3, 6'd5, 1'b0);
        repeat (5) step();
        check_val("drop_addr3_cnt", 32'(drop_cnt - dr0), 32'd1);
        check_val("drop_addr3_pv", 32'(pv_cycles - pv0), 32'd0);
        check_val("drop_addr3_pr", 32'(pr_cycles - pr0), 32'd0);
        check_val("drop_addr3_idle", 32'(req_ready), 32'd1);
        dr0 = drop_cnt;
        send_pkt(2'd0, 6'd0, 1'b0);
        repeat (5) step();
        check_val("drop_len0_cnt", 32'(drop_cnt - dr0), 32'd1);
        check_val("drop_len0_pv", 32'(pv_cycles - pv0), 32'd0);

        // Maximum length packet.
        for (int i = 0; i < 63; i++) pl[i] = 8'(i);
        td0 = tx_done_cnt;
        send_pkt(2'd2, 6'd63, 1'b1);
        wait_pkt_end();
        check_val("max_tx_done_cnt", 32'(tx_done_cnt - td0), 32'd1);

        // Random packets.
        for (int n = 0; n < 4; n++) begin
            logic [1:0] ra;
            logic [5:0] rl;
            ra = 2'($urandom_range(0, 2));
            rl = 6'($urandom_range(1, 63));
            for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
            send_pkt(ra, rl, 1'b1);
            wait_pkt_end();
        end
        check_val("err_count_quiet", 32'(err_count), 32'd0);

        // Reset during payload byte 2 of 10.
        for (int i = 0; i < 10; i++) pl[i] = 8'h10 + 8'(i);
        send_pkt(2'd0, 6'd10, 1'b0);
        budget = 0;
        while (!(pkt_valid && data_out == pl[2]) && budget < 50) begin
            step();
            budget++;
        end
        check_val("abort_byte2_seen", 32'(data_out), 32'h12);
        reset = 1'b1;
        step();
        check_val("abort_pkt_valid", 32'(pkt_valid), 32'd0);
        check_val("abort_data_out", 32'(data_out), 32'd0);
        check_val("abort_req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        td0 = tx_done_cnt;
        pv0 = pv_cycles;
        repeat (30) step();
        check_val("abort_no_tx_done", 32'(tx_done_cnt - td0), 32'd0);
        check_val("abort_no_pkt_valid", 32'(pv_cycles - pv0), 32'd0);

        // err counting and saturation.
        err = 1'b1;
        pl[0] = 8'h5A;
        for (int n = 1; n <= 300; n++) begin
            send_pkt(2'd0, 6'd1, 1'b0);
            wait_pkt_end();
            if (n == 1) check_val("err_count_1", 32'(err_count), 32'd1);
            if (n == 255) check_val("err_count_255", 32'(err_count), 32'd255);
        end
        check_val("err_count_sat", 32'(err_count), 32'd255);
        err = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
